// File: rtl/ce_pulse_gen.sv
// Clock-enable generator for falling-edge CE flops: continuous divide-by-(DIV+1)
// or a burst of BURST_LEN pulses closed by a DONE strobe. All outputs launch on rising C.
module ce_pulse_gen #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             START,
    input  logic             STOP,
    input  logic             MODE,
    input  logic [WIDTH-1:0] DIV,
    input  logic [7:0]       BURST_LEN,
    output logic             CE,
    output logic             DONE,
    output logic             BUSY,
    output logic [7:0]       PCNT
);

    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [WIDTH-1:0] div_lat_q, div_lat_d;
    logic [CW-1:0]    len_lat_q, len_lat_d;
    logic [CW-1:0]    pcnt_q,    pcnt_d;
    logic             ce_q,      ce_d;
    logic             done_q,    done_d;
    logic             busy_q,    busy_d;
    logic             tick;

    // Divider expiry: reload instead of decrementing past zero.
    assign tick = (div_cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        div_lat_d = div_lat_q;
        len_lat_d = len_lat_q;
        pcnt_d    = pcnt_q;
        ce_d      = 1'b0;
        done_d    = 1'b0;

        if (STOP) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        div_lat_d = DIV;
                        len_lat_d = BURST_LEN;
                        div_cnt_d = DIV;
                        pcnt_d    = '0;
                        if (!MODE) begin
                            state_d = RUN;
                        end else if (BURST_LEN == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = BURST;
                        end
                    end
                end
                RUN, BURST: begin
                    if (tick) begin
                        ce_d      = 1'b1;
                        div_cnt_d = div_lat_q;
                    end else begin
                        div_cnt_d = div_cnt_q - WIDTH'(1);
                    end
                    // Final burst pulse: DONE rides alongside the last CE.
                    if (state_q == BURST && tick) begin
                        pcnt_d = pcnt_q + CW'(1);
                        if (pcnt_d == len_lat_q) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            div_lat_q <= '0;
            len_lat_q <= '0;
            pcnt_q    <= '0;
            ce_q      <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            div_lat_q <= div_lat_d;
            len_lat_q <= len_lat_d;
            pcnt_q    <= pcnt_d;
            ce_q      <= ce_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign CE   = ce_q;
    assign DONE = done_q;
    assign BUSY = busy_q;
    assign PCNT = pcnt_q;

endmodule

// File: doc/ce_pulse_gen.md
# ce_pulse_gen

Programmable clock-enable generator that sits directly upstream of the team's falling-edge clock-enabled flip-flop primitives and drives their CE pin. CE is launched on the rising edge of C, so a consumer clocked on the falling edge of the same C samples a stable CE half a cycle later. Two modes are supported: continuous divide-by-(DIV+1), and a burst of BURST_LEN enable pulses followed by a DONE strobe.

## Interface
- WIDTH, 8, width of the divide counter and of the DIV input
- C  input  1  clock; all state updates on the rising edge
- CLR  input  1  reset, asynchronous, active-high
- START  input  1  sampled in IDLE; begins RUN (MODE=0) or BURST (MODE=1)
- STOP  input  1  returns to IDLE from any state; beats START
- MODE  input  1  0 = continuous, 1 = burst; sampled only with START
- DIV  input  WIDTH  CE period minus one; latched on the accepted START
- BURST_LEN  input  8  number of CE pulses in a burst; latched on the accepted START
- CE  output  1  registered enable pulse, one C cycle wide
- DONE  output  1  registered one-cycle strobe at burst completion
- BUSY  output  1  registered; high whenever state is not IDLE
- PCNT  output  8  CE pulses issued in the current or most recent burst

## Operation
- States: IDLE, RUN, BURST.
- Reset:
  - CLR high, or global GSR high, forces the following immediately and independently of C: state=IDLE, CE=0, DONE=0, BUSY=0, PCNT=0, div_cnt=0, div_lat=0, len_lat=0.
  - Normal operation resumes on the first rising edge of C after both CLR and GSR are low.
- IDLE:
  - START=1 and STOP=0: div_lat<=DIV, len_lat<=BURST_LEN, div_cnt<=DIV, PCNT<=0.
  - Next state is RUN if MODE=0, BURST if MODE=1.
  - Exception: MODE=1 with BURST_LEN=0 stays in IDLE and sets DONE<=1 on that same edge.
- RUN and BURST, each rising edge:
  - div_cnt==0: CE<=1, div_cnt<=div_lat.
  - Otherwise: CE<=0, div_cnt<=div_cnt-1.
- BURST only:
  - Each issued CE increments PCNT.
  - When the issued CE brings PCNT to len_lat: DONE<=1 on the same edge and the next state is IDLE.
  - CE and DONE are high together in that cycle.
- STOP=1 in any state:
  - Takes effect on the edge that samples it: CE<=0, DONE<=0, state<=IDLE.
  - PCNT holds its value.
  - STOP wins over a simultaneous START and over a simultaneous final CE; an aborted burst never produces DONE.
- START while BUSY is ignored.
- Changes to DIV, MODE or BURST_LEN while BUSY are ignored until the next accepted START.
- DIV=0 gives CE held continuously high in RUN, and back-to-back pulses in BURST.
- div_cnt arithmetic is unsigned WIDTH-bit. It never underflows because it reloads at 0.
- PCNT is 8-bit and cannot wrap because it is bounded by len_lat ≤ 255.
- DONE and CE are high for exactly one cycle per event, except CE with DIV=0.

## Timing
- The accepting edge is edge 0. The first CE is high in the cycle after edge DIV+1.
- CE period is DIV+1 cycles.
- BUSY rises in the cycle after edge 0.
- BUSY falls in the cycle after the final-CE edge (burst end) or the STOP edge.
- DONE coincides with the last CE. BUSY is already low during the DONE cycle.
- The earliest restart is a START sampled in the DONE cycle.
- A burst's total length from the START edge to the last CE edge is BURST_LEN*(DIV+1) cycles.
- All outputs change only on the rising edge of C, except the asynchronous clear.

## Test plan
- Reset: CLR pulsed mid-burst between clock edges, with DIV=3, BURST_LEN=5 -> all outputs go to 0 without a clock edge; after release, START is required before any CE appears.
- Continuous: MODE=0, DIV=2, START, run 12 cycles, then STOP -> CE high 1 of every 3 cycles, first at edge 3, 4 pulses total; STOP edge forces CE=0 and BUSY=0.
- Burst: MODE=1, DIV=1, BURST_LEN=4 -> CE at edges 2, 4, 6, 8; DONE high together with the 4th CE; PCNT=4; BUSY low afterwards.
- Edge cases:
  - BURST_LEN=0 -> DONE at edge 0 with no CE and BUSY never high.
  - DIV=0, BURST_LEN=3 -> CE at edges 1, 2, 3 back-to-back.
- Conflicts:
  - START and STOP in the same cycle in IDLE -> remains IDLE.
  - STOP on the edge of the final CE of BURST_LEN=2 -> no CE, no DONE, PCNT=1.
  - START while BUSY -> ignored.
- Falling-edge consumer: connect CE to a falling-edge clock-enabled D flop with D toggling every cycle -> the flop updates only on the falling edge inside each CE-high cycle; DIV=3 gives an update every 4 cycles.
